streaming_frame_writer: RTL

- Capture-side DMA writer directly downstream of the streaming register block. It consumes that block's capture control, ping-pong write-region addresses and capture_height_width.
- Accepts a 32-bit pixel stream (one pixel per word), buffers it in an internal FIFO and writes whole frames to DDR through an AXI master write port.
- Frames alternate between region 0 and region 1.
- Addresses are in 32-bit-word units: +1 per beat, matching the lab AXI interconnect.

---
 rtl/streaming_frame_writer_if.sv | 36 +++
 rtl/streaming_frame_writer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/streaming_frame_writer_if.sv
// AXI write-channel bundle between the frame writer (master) and DDR interconnect (slave).
interface streaming_frame_writer_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] MASTER_WR_ADDR_ID;
  logic [31:0]         MASTER_WR_ADDR;
  logic [7:0]          MASTER_WR_ADDR_LEN;
  logic [1:0]          MASTER_WR_ADDR_BURST;
  logic                MASTER_WR_ADDR_VALID;
  logic                MASTER_WR_ADDR_READY;
  logic [31:0]         MASTER_WR_DATA;
  logic [3:0]          MASTER_WR_STRB;
  logic                MASTER_WR_DATA_LAST;
  logic                MASTER_WR_DATA_VALID;
  logic                MASTER_WR_DATA_READY;
  logic [ID_WIDTH-1:0] MASTER_WR_BACK_ID;
  logic [1:0]          MASTER_WR_BACK_RESP;
  logic                MASTER_WR_BACK_VALID;
  logic                MASTER_WR_BACK_READY;

  modport master (
    output MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
           MASTER_WR_ADDR_VALID, MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST,
           MASTER_WR_DATA_VALID, MASTER_WR_BACK_READY,
    input  MASTER_WR_ADDR_READY, MASTER_WR_DATA_READY, MASTER_WR_BACK_ID,
           MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID
  );

  modport slave (
    input  MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
           MASTER_WR_ADDR_VALID, MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST,
           MASTER_WR_DATA_VALID, MASTER_WR_BACK_READY,
    output MASTER_WR_ADDR_READY, MASTER_WR_DATA_READY, MASTER_WR_BACK_ID,
           MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID
  );
endinterface

// File: rtl/streaming_frame_writer.sv
// Capture-side DMA writer: buffers a pixel stream in a FIFO and writes whole
// frames into alternating DDR regions as AXI INCR bursts (word addressing).
module streaming_frame_writer #(
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int WR_ID      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic [31:0] start_write_addr0,
  input  logic [31:0] end_write_addr0,
  input  logic [31:0] start_write_addr1,
  input  logic [31:0] end_write_addr1,
  input  logic [31:0] capture_height_width,
  input  logic [31:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        frame_done,
  output logic        frame_buf,
  output logic        clip_err,
  output logic        resp_err,
  streaming_frame_writer_if.master axi
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;
  state_t state;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [31:0]   frame_words, accepted, remaining, next_addr;
  logic [8:0]    blen, beat, blen_next;
  logic          tgt_buf;
  logic          full, empty, start, push, pop, flush, last_beat;
  logic [31:0]   hw_words, start_words;
  logic [32:0]   rsz;
  logic          clip;
  logic          unused_id;

  assign unused_id = ^axi.MASTER_WR_BACK_ID;

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  assign start = (state == S_IDLE) && s_valid && s_sof && capture_en;
  // Idle swallows stray non-sof beats; in-frame acceptance stops at frame_words.
  assign s_ready = (state == S_IDLE) || (!full && (accepted < frame_words));
  assign push    = s_valid && s_ready && ((state != S_IDLE) || start);
  assign pop     = (state == S_DATA) && !empty && axi.MASTER_WR_DATA_READY;
  assign last_beat = (beat == blen - 9'd1);
  // Leaving a frame (done or aborted) drops anything left in the FIFO.
  assign flush = (state == S_DONE) || ((state == S_WAIT) && !capture_en) ||
                 ((state == S_RESP) && axi.MASTER_WR_BACK_VALID && (remaining != '0) && !capture_en);

  // Frame size and clamp against the region the next frame will land in.
  always_comb begin
    hw_words  = 32'(capture_height_width[31:16]) * 32'(capture_height_width[15:0]);
    rsz       = frame_buf ? ({1'b0, end_write_addr0} - {1'b0, start_write_addr0} + 33'd1)
                          : ({1'b0, end_write_addr1} - {1'b0, start_write_addr1} + 33'd1);
    clip      = {1'b0, hw_words} > rsz;
    start_words = clip ? rsz[31:0] : hw_words;
    blen_next = (remaining < 32'(BURST_LEN)) ? remaining[8:0] : 9'(BURST_LEN);
  end

  assign axi.MASTER_WR_ADDR_ID    = ID_WIDTH'(WR_ID);
  assign axi.MASTER_WR_ADDR_BURST = 2'b01;
  assign axi.MASTER_WR_STRB       = 4'hF;
  assign axi.MASTER_WR_DATA       = mem[rptr];
  assign axi.MASTER_WR_DATA_VALID = (state == S_DATA) && !empty;
  assign axi.MASTER_WR_DATA_LAST  = (state == S_DATA) && last_beat;

  // FIFO storage (no reset needed, pointers qualify contents).
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= s_data;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Frame/burst sequencer with registered AXI control and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_done  <= 1'b0;
      frame_buf   <= 1'b1;
      clip_err    <= 1'b0;
      resp_err    <= 1'b0;
      tgt_buf     <= 1'b0;
      frame_words <= '0;
      accepted    <= '0;
      remaining   <= '0;
      next_addr   <= '0;
      blen        <= '0;
      beat        <= '0;
      axi.MASTER_WR_ADDR       <= '0;
      axi.MASTER_WR_ADDR_LEN   <= '0;
      axi.MASTER_WR_ADDR_VALID <= 1'b0;
      axi.MASTER_WR_BACK_READY <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start)     accepted <= 32'd1;
      else if (push) accepted <= accepted + 32'd1;
      case (state)
        S_IDLE: if (start) begin
          tgt_buf     <= ~frame_buf;
          next_addr   <= frame_buf ? start_write_addr0 : start_write_addr1;
          clip_err    <= clip;
          resp_err    <= 1'b0;
          frame_words <= start_words;
          remaining   <= start_words;
          if (start_words == '0) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
            frame_buf  <= ~frame_buf;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!capture_en) begin
            state <= S_IDLE;
          end else if (32'(cnt) >= 32'(blen_next)) begin
            axi.MASTER_WR_ADDR       <= next_addr;
            axi.MASTER_WR_ADDR_LEN   <= 8'(blen_next - 9'd1);
            axi.MASTER_WR_ADDR_VALID <= 1'b1;
            blen      <= blen_next;
            remaining <= remaining - 32'(blen_next);
            beat      <= '0;
            state     <= S_ADDR;
          end
        end
        S_ADDR: if (axi.MASTER_WR_ADDR_READY) begin
          axi.MASTER_WR_ADDR_VALID <= 1'b0;
          state <= S_DATA;
        end
        S_DATA: if (pop) begin
          beat <= beat + 9'd1;
          if (last_beat) begin
            axi.MASTER_WR_BACK_READY <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: if (axi.MASTER_WR_BACK_VALID) begin
          axi.MASTER_WR_BACK_READY <= 1'b0;
          if (axi.MASTER_WR_BACK_RESP != 2'b00) resp_err <= 1'b1;
          if (remaining == '0) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
            frame_buf  <= tgt_buf;
          end else if (!capture_en) begin
            state <= S_IDLE;
          end else begin
            next_addr <= next_addr + 32'(blen);
            state     <= S_WAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
